// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
//   Shares the scoreboard write-back port among NR_REQ functional units.
//   A round-robin pointer picks one valid FU per cycle. That FU's result is
//   registered and shown on the wb_* outputs one cycle later. The scoreboard
//   never back-pressures, so sustained throughput is one result per cycle.
//
// Ports
//   clk_i, rst_i         clock, synchronous active-high reset
//   flush_i              drop whatever is accepted this cycle
//   req_valid_i          per-FU result valid
//   req_ready_o          per-FU grant, one-hot or zero
//   req_trans_id_i       packed per-FU transaction IDs, FU i at [i*TID_W +: TID_W]
//   req_data_i           packed per-FU results
//   req_ex_valid_i       per-FU exception flag
//   req_ex_cause_i       packed per-FU exception causes (64 bits each)
//   wb_valid_o           write-back valid
//   wb_trans_id_o        write-back transaction ID
//   wb_data_o            write-back data
//   wb_ex_valid_o        write-back exception flag (meaningful only with wb_valid_o)
//   wb_ex_cause_o        write-back exception cause
//   wb_src_o             index of the FU that produced the current output
module wb_port_arbiter #(
  parameter int NR_REQ = 3,
  parameter int DATA_W = 64,
  parameter int TID_W  = 3
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        flush_i,
  input  logic [NR_REQ-1:0]           req_valid_i,
  output logic [NR_REQ-1:0]           req_ready_o,
  input  logic [NR_REQ*TID_W-1:0]     req_trans_id_i,
  input  logic [NR_REQ*DATA_W-1:0]    req_data_i,
  input  logic [NR_REQ-1:0]           req_ex_valid_i,
  input  logic [NR_REQ*64-1:0]        req_ex_cause_i,
  output logic                        wb_valid_o,
  output logic [TID_W-1:0]            wb_trans_id_o,
  output logic [DATA_W-1:0]           wb_data_o,
  output logic                        wb_ex_valid_o,
  output logic [63:0]                 wb_ex_cause_o,
  output logic [$clog2(NR_REQ)-1:0]   wb_src_o
);

  localparam int PTR_W = $clog2(NR_REQ);
  localparam logic [PTR_W:0]   NR_REQ_EXT = (PTR_W+1)'(NR_REQ);
  localparam logic [PTR_W-1:0] LAST_IDX   = PTR_W'(NR_REQ - 1);

  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  ptr_next;
  logic [PTR_W-1:0]  grant_idx;
  logic              grant_any;
  logic [PTR_W:0]    scan_sum;
  logic [PTR_W:0]    scan_idx;

  // Priority scan starting at ptr. The wrap is done by subtraction because
  // NR_REQ need not be a power of two, so a plain bit truncation would land
  // on indices that do not exist.
  always_comb begin
    // NOTE: every variable gets a default before the loop so no path leaves
    // it unassigned; otherwise synthesis would infer a latch.
    grant_any = 1'b0;
    grant_idx = '0;
    scan_sum  = '0;
    scan_idx  = '0;
    for (int k = 0; k < NR_REQ; k++) begin
      scan_sum = {1'b0, ptr} + (PTR_W+1)'(k);
      scan_idx = (scan_sum >= NR_REQ_EXT) ? scan_sum - NR_REQ_EXT : scan_sum;
      if (!grant_any && req_valid_i[scan_idx[PTR_W-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = scan_idx[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    req_ready_o = '0;
    if (grant_any && !rst_i) req_ready_o[grant_idx] = 1'b1;
  end

  assign ptr_next = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;

  // The pointer keeps moving during flush so that fairness is kept across
  // flushes. Flush only suppresses wb_valid_o. The payload registers may
  // still load, because their contents are ignored while valid is low.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (rst_i) begin
      ptr           <= '0;
      wb_valid_o    <= 1'b0;
      wb_trans_id_o <= '0;
      wb_data_o     <= '0;
      wb_ex_valid_o <= 1'b0;
      wb_ex_cause_o <= '0;
      wb_src_o      <= '0;
    end else begin
      wb_valid_o <= grant_any && !flush_i;
      if (grant_any) begin
        ptr           <= ptr_next;
        wb_trans_id_o <= req_trans_id_i[grant_idx*TID_W +: TID_W];
        wb_data_o     <= req_data_i[grant_idx*DATA_W +: DATA_W];
        wb_ex_valid_o <= req_ex_valid_i[grant_idx];
        wb_ex_cause_o <= req_ex_cause_i[grant_idx*64 +: 64];
        wb_src_o      <= grant_idx;
      end
    end
  end

  // Protocol checks: grants are one-hot, go only to valid FUs, and a stalled
  // FU must keep its payload stable until it is accepted.
  a_ready_onehot : assert property (@(posedge clk_i) $onehot0(req_ready_o));
  a_ready_valid  : assert property (@(posedge clk_i) disable iff (rst_i)
                                    (req_ready_o & ~req_valid_i) == '0);

  for (genvar i = 0; i < NR_REQ; i++) begin : g_stall_chk
    a_stall_stable : assert property (@(posedge clk_i) disable iff (rst_i)
      (req_valid_i[i] && !req_ready_o[i]) |=>
        ($stable(req_trans_id_i[i*TID_W +: TID_W]) &&
         $stable(req_data_i[i*DATA_W +: DATA_W]) &&
         $stable(req_ex_valid_i[i]) &&
         $stable(req_ex_cause_i[i*64 +: 64])));
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter using the default configuration
// (3 FUs, 64-bit data, 3-bit transaction IDs). Inputs change and outputs are
// sampled 1 time unit after a rising edge, well away from the next edge.
module tb_wb_port_arbiter;

  localparam int NR_REQ = 3;
  localparam int DATA_W = 64;
  localparam int TID_W  = 3;

  logic                      clk_i = 1'b0;
  logic                      rst_i;
  logic                      flush_i;
  logic [NR_REQ-1:0]         req_valid_i;
  logic [NR_REQ-1:0]         req_ready_o;
  logic [NR_REQ*TID_W-1:0]   req_trans_id_i;
  logic [NR_REQ*DATA_W-1:0]  req_data_i;
  logic [NR_REQ-1:0]         req_ex_valid_i;
  logic [NR_REQ*64-1:0]      req_ex_cause_i;
  logic                      wb_valid_o;
  logic [TID_W-1:0]          wb_trans_id_o;
  logic [DATA_W-1:0]         wb_data_o;
  logic                      wb_ex_valid_o;
  logic [63:0]               wb_ex_cause_o;
  logic [1:0]                wb_src_o;

  int vectors     = 0;
  int miscompares = 0;

  wb_port_arbiter #(.NR_REQ(NR_REQ), .DATA_W(DATA_W), .TID_W(TID_W)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .flush_i        (flush_i),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_trans_id_i (req_trans_id_i),
    .req_data_i     (req_data_i),
    .req_ex_valid_i (req_ex_valid_i),
    .req_ex_cause_i (req_ex_cause_i),
    .wb_valid_o     (wb_valid_o),
    .wb_trans_id_o  (wb_trans_id_o),
    .wb_data_o      (wb_data_o),
    .wb_ex_valid_o  (wb_ex_valid_o),
    .wb_ex_cause_o  (wb_ex_cause_o),
    .wb_src_o       (wb_src_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] observed,
                       input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic set_fu(input int i, input logic v, input logic [TID_W-1:0] tid,
                        input logic [DATA_W-1:0] data, input logic exv,
                        input logic [63:0] cause);
    req_valid_i[i]                    = v;
    req_trans_id_i[i*TID_W +: TID_W]  = tid;
    req_data_i[i*DATA_W +: DATA_W]    = data;
    req_ex_valid_i[i]                 = exv;
    req_ex_cause_i[i*64 +: 64]        = cause;
  endtask

  task automatic check_wb(input string tag, input logic [TID_W-1:0] tid,
                          input logic [1:0] src);
    check({tag, ".valid"}, 64'(wb_valid_o), 64'd1);
    check({tag, ".tid"},   64'(wb_trans_id_o), 64'(tid));
    check({tag, ".src"},   64'(wb_src_o), 64'(src));
  endtask

  initial begin
    rst_i          = 1'b1;
    flush_i        = 1'b0;
    req_valid_i    = '0;
    req_trans_id_i = '0;
    req_data_i     = '0;
    req_ex_valid_i = '0;
    req_ex_cause_i = '0;

    // Reset: ready stays low even with every FU valid.
    req_valid_i = 3'b111;
    #1;
    check("rst.ready", 64'(req_ready_o), 64'd0);
    tick();
    check("rst.wb_valid", 64'(wb_valid_o), 64'd0);
    check("rst.wb_data",  wb_data_o, 64'd0);
    check("rst.wb_src",   64'(wb_src_o), 64'd0);
    req_valid_i = '0;
    rst_i       = 1'b0;
    #1;

    // Test 1: single FU1 result, one-cycle latency, then a bubble.
    set_fu(1, 1'b1, 3'd5, 64'hDEADBEEF, 1'b0, 64'd0);
    #1;
    check("t1.ready", 64'(req_ready_o), 64'b010);
    tick();                                   // ptr -> 2
    set_fu(1, 1'b0, 3'd5, 64'hDEADBEEF, 1'b0, 64'd0);
    #1;
    check_wb("t1.out", 3'd5, 2'd1);
    check("t1.data", wb_data_o, 64'hDEADBEEF);
    check("t1.ready_idle", 64'(req_ready_o), 64'd0);
    tick();
    check("t1.bubble", 64'(wb_valid_o), 64'd0);
    check("t1.data_hold", wb_data_o, 64'hDEADBEEF);

    // Test 3: wrap from ptr=2 to FU0, then ptr=1 favours FU1 over FU0.
    set_fu(0, 1'b1, 3'd3, 64'h33, 1'b0, 64'd0);
    #1;
    check("t3.wrap_ready", 64'(req_ready_o), 64'b001);
    tick();                                   // ptr -> 1
    check_wb("t3.wrap_out", 3'd3, 2'd0);
    set_fu(0, 1'b1, 3'd4, 64'h44, 1'b0, 64'd0);
    set_fu(1, 1'b1, 3'd6, 64'h66, 1'b0, 64'd0);
    #1;
    check("t3.prio_ready", 64'(req_ready_o), 64'b010);
    tick();                                   // ptr -> 2; FU0 stalled
    check_wb("t3.prio_out", 3'd6, 2'd1);
    set_fu(1, 1'b0, 3'd6, 64'h66, 1'b0, 64'd0);
    #1;
    check("t3.stall_ready", 64'(req_ready_o), 64'b001);
    tick();                                   // ptr -> 1
    check_wb("t3.stall_out", 3'd4, 2'd0);
    check("t3.stall_data", wb_data_o, 64'h44);
    set_fu(0, 1'b0, 3'd4, 64'h44, 1'b0, 64'd0);

    // Test 4: exception payload from FU2 passes through unmodified.
    set_fu(2, 1'b1, 3'd7, 64'h1234, 1'b1, 64'h2);
    #1;
    check("t4.ready", 64'(req_ready_o), 64'b100);
    tick();                                   // ptr -> 0
    set_fu(2, 1'b0, 3'd7, 64'h1234, 1'b1, 64'h2);
    check_wb("t4.out", 3'd7, 2'd2);
    check("t4.ex_valid", 64'(wb_ex_valid_o), 64'd1);
    check("t4.ex_cause", wb_ex_cause_o, 64'h2);
    check("t4.data", wb_data_o, 64'h1234);

    // Test 5: flush with FU0 valid completes the handshake but drops the result.
    flush_i = 1'b1;
    set_fu(0, 1'b1, 3'd0, 64'hA0, 1'b0, 64'd0);
    #1;
    check("t5.ready", 64'(req_ready_o), 64'b001);
    tick();                                   // ptr -> 1
    flush_i = 1'b0;
    check("t5.dropped", 64'(wb_valid_o), 64'd0);
    set_fu(1, 1'b1, 3'd1, 64'hA1, 1'b0, 64'd0);
    set_fu(2, 1'b1, 3'd2, 64'hA2, 1'b0, 64'd0);
    #1;
    check("t5.next_ready", 64'(req_ready_o), 64'b010);
    tick();                                   // ptr -> 2
    check_wb("t5.next_out", 3'd1, 2'd1);
    check("t6.pre_ready", 64'(req_ready_o), 64'b100);
    tick();                                   // ptr -> 0
    check_wb("t6.pre_out", 3'd2, 2'd2);

    // Test 6: reset mid-stream clears the outputs and drops the in-flight result.
    tick();                                   // grant FU0, ptr -> 1
    check_wb("t6.inflight", 3'd0, 2'd0);
    rst_i = 1'b1;
    #1;
    check("t6.rst_ready", 64'(req_ready_o), 64'd0);
    tick();
    check("t6.rst_valid", 64'(wb_valid_o), 64'd0);
    check("t6.rst_tid",   64'(wb_trans_id_o), 64'd0);
    check("t6.rst_data",  wb_data_o, 64'd0);
    check("t6.rst_src",   64'(wb_src_o), 64'd0);
    check("t6.rst_ex",    64'(wb_ex_valid_o), 64'd0);
    check("t6.rst_cause", wb_ex_cause_o, 64'd0);
    rst_i = 1'b0;
    #1;

    // Test 2: all FUs valid after reset -> grants 0,1,2,0,1,2 with no bubbles.
    for (int k = 0; k < 6; k++) begin
      logic [1:0] g;
      g = 2'(k % 3);
      check($sformatf("t2.ready%0d", k), 64'(req_ready_o), 64'(3'b001 << g));
      tick();
      check_wb($sformatf("t2.out%0d", k), 3'(g), g);
      check($sformatf("t2.data%0d", k), wb_data_o, 64'hA0 + 64'(g));
    end
    req_valid_i = '0;
    tick();
    check("t2.drain", 64'(wb_valid_o), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
